// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO
//             registers. It accepts one operation per start pulse and commits
//             HI/LO atomically after a fixed latency. mthi/mtlo write in a
//             single cycle.
//  Ports    : clk    - rising-edge clock
//             reset  - asynchronous, active-low reset
//             start  - launch the operation on op/a/b (ignored while running)
//             op     - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                      6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 none
//             a, b   - rs / rt operands
//             busy   - registered; high while a multi-cycle op is in flight
//             hi, lo - committed architectural HI / LO
//  Revision : 1.0  initial release
// ============================================================================
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [3:0] c_OP_MULT  = 4'd1;
   localparam logic [3:0] c_OP_MULTU = 4'd2;
   localparam logic [3:0] c_OP_DIV   = 4'd3;
   localparam logic [3:0] c_OP_DIVU  = 4'd4;
   localparam logic [3:0] c_OP_MTHI  = 4'd5;
   localparam logic [3:0] c_OP_MTLO  = 4'd6;
   localparam logic [3:0] c_OP_MADD  = 4'd7;
   localparam logic [3:0] c_OP_MADDU = 4'd8;
   localparam logic [3:0] c_OP_MSUB  = 4'd9;
   localparam logic [3:0] c_OP_MSUBU = 4'd10;

   // Counter holds N-1 for the longest latency.
   localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

   localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
   // With a latency of one the result lands on the very next edge, so busy
   // is never raised.
   localparam logic c_MULT_BUSY = (MULT_CYCLES > 1);
   localparam logic c_DIV_BUSY  = (DIV_CYCLES > 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              r_state,  w_nextState;
   logic [c_CNT_W-1:0]  r_count,  w_nextCount;
   logic                r_busy,   w_nextBusy;
   logic [3:0]          r_op,     w_nextOp;
   logic [WIDTH-1:0]    r_a,      w_nextA;
   logic [WIDTH-1:0]    r_b,      w_nextB;
   logic [WIDTH-1:0]    r_hi,     w_nextHi;
   logic [WIDTH-1:0]    r_lo,     w_nextLo;

   // ------------------------------------------------------------------------
   // Datapath, driven purely from the latched operands so that a/b/op may
   // change freely once the op has launched.
   // ------------------------------------------------------------------------
   logic                 w_signedOp;
   logic [2*WIDTH-1:0]   w_aExt, w_bExt, w_prod, w_acc;
   logic                 w_aNeg, w_bNeg;
   logic [WIDTH-1:0]     w_aMag, w_bMag, w_quoMag, w_remMag, w_quo, w_rem;

   assign w_signedOp = (r_op == c_OP_MULT) || (r_op == c_OP_MADD) ||
                       (r_op == c_OP_MSUB) || (r_op == c_OP_DIV);

   assign w_aExt = w_signedOp ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
   assign w_bExt = w_signedOp ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
   // Sign-extended operands make a 2W-bit modulo product equal the signed one.
   assign w_prod = w_aExt * w_bExt;
   assign w_acc  = {r_hi, r_lo};

   // Signed divide via magnitudes. The most-negative / -1 case falls out
   // naturally: |min| = min as unsigned, quotient negates back to min,
   // remainder is 0.
   assign w_aNeg   = w_signedOp && r_a[WIDTH-1];
   assign w_bNeg   = w_signedOp && r_b[WIDTH-1];
   assign w_aMag   = w_aNeg ? -r_a : r_a;
   assign w_bMag   = w_bNeg ? -r_b : r_b;
   assign w_quoMag = w_aMag / w_bMag;
   assign w_remMag = w_aMag % w_bMag;
   assign w_quo    = (w_aNeg ^ w_bNeg) ? -w_quoMag : w_quoMag;
   assign w_rem    = w_aNeg ? -w_remMag : w_remMag;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_op    <= 4'd0;
         r_a     <= '0;
         r_b     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_nextState;
         r_count <= w_nextCount;
         r_busy  <= w_nextBusy;
         r_op    <= w_nextOp;
         r_a     <= w_nextA;
         r_b     <= w_nextB;
         r_hi    <= w_nextHi;
         r_lo    <= w_nextLo;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state / commit logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_nextState = r_state;
      w_nextCount = r_count;
      w_nextBusy  = r_busy;
      w_nextOp    = r_op;
      w_nextA     = r_a;
      w_nextB     = r_b;
      w_nextHi    = r_hi;
      w_nextLo    = r_lo;

      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               unique case (op)
                  c_OP_MULT, c_OP_MULTU, c_OP_MADD, c_OP_MADDU, c_OP_MSUB, c_OP_MSUBU: begin
                     w_nextState = S_RUN;
                     w_nextOp    = op;
                     w_nextA     = a;
                     w_nextB     = b;
                     w_nextCount = c_MULT_LOAD;
                     w_nextBusy  = c_MULT_BUSY;
                  end
                  c_OP_DIV, c_OP_DIVU: begin
                     w_nextState = S_RUN;
                     w_nextOp    = op;
                     w_nextA     = a;
                     w_nextB     = b;
                     w_nextCount = c_DIV_LOAD;
                     w_nextBusy  = c_DIV_BUSY;
                  end
                  c_OP_MTHI: w_nextHi = a;
                  c_OP_MTLO: w_nextLo = a;
                  default: ;
               endcase
            end
         end

         S_RUN: begin
            // start is not looked at here: anything arriving while an op is
            // in flight, including on the commit edge, is dropped.
            if (r_count == '0) begin
               w_nextState = S_IDLE;
               w_nextBusy  = 1'b0;
               unique case (r_op)
                  c_OP_MULT, c_OP_MULTU: {w_nextHi, w_nextLo} = w_prod;
                  c_OP_MADD, c_OP_MADDU: {w_nextHi, w_nextLo} = w_acc + w_prod;
                  c_OP_MSUB, c_OP_MSUBU: {w_nextHi, w_nextLo} = w_acc - w_prod;
                  c_OP_DIV, c_OP_DIVU: begin
                     // Divide by zero keeps the previous HI/LO.
                     if (r_b != '0) begin
                        w_nextHi = w_rem;
                        w_nextLo = w_quo;
                     end
                  end
                  default: ;
               endcase
            end else begin
               w_nextCount = r_count - c_CNT_ONE;
               // busy drops one edge before the commit, so it is high for
               // N-1 cycles and the stall releases in time for the
               // dependent instruction to read the committed value.
               w_nextBusy  = (r_count > c_CNT_ONE);
            end
         end

         default: w_nextState = S_IDLE;
      endcase
   end

   assign busy = r_busy;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit
//  Purpose  : Directed scoreboard bench for md_unit (WIDTH=32, MULT=5, DIV=10).
//             Stimulus pushes per-cycle expectations of busy/hi/lo into a
//             queue; a monitor on the falling edge pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_md_unit;

   localparam int c_MULT_N = 5;
   localparam int c_DIV_N  = 10;

   localparam logic [3:0] c_NONE  = 4'd0;
   localparam logic [3:0] c_MULT  = 4'd1;
   localparam logic [3:0] c_MULTU = 4'd2;
   localparam logic [3:0] c_DIV   = 4'd3;
   localparam logic [3:0] c_DIVU  = 4'd4;
   localparam logic [3:0] c_MTHI  = 4'd5;
   localparam logic [3:0] c_MTLO  = 4'd6;
   localparam logic [3:0] c_MADD  = 4'd7;
   localparam logic [3:0] c_MADDU = 4'd8;
   localparam logic [3:0] c_MSUB  = 4'd9;
   localparam logic [3:0] c_MSUBU = 4'd10;

   logic        clk = 1'b0;
   logic        rstN;
   logic        startIn;
   logic [3:0]  opIn;
   logic [31:0] aIn, bIn;
   logic        busyOut;
   logic [31:0] hiOut, loOut;

   md_unit #(
      .WIDTH       (32),
      .MULT_CYCLES (c_MULT_N),
      .DIV_CYCLES  (c_DIV_N)
   ) dut (
      .clk   (clk),
      .reset (rstN),
      .start (startIn),
      .op    (opIn),
      .a     (aIn),
      .b     (bIn),
      .busy  (busyOut),
      .hi    (hiOut),
      .lo    (loOut)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic        expBusy;
      logic [31:0] expHi;
      logic [31:0] expLo;
      string       name;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] curHi = 32'd0;
   logic [31:0] curLo = 32'd0;

   task automatic chk(input string nm, input string field, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s @cyc %0d: got=%08h expected=%08h", nm, field, cyc, act, exp);
      end
   endtask

   // Monitor: compares every queued expectation on the cycle it is due.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
               total++;
               bad++;
               $display("FAIL %s missed: due cyc %0d, now %0d", e.name, e.cyc, cyc);
            end else begin
               chk(e.name, "busy", {31'd0, busyOut}, {31'd0, e.expBusy});
               chk(e.name, "hi",   hiOut, e.expHi);
               chk(e.name, "lo",   loOut, e.expLo);
            end
         end
      end
   end

   // Expectations for an op whose start edge is cycle s and which commits
   // n edges later (n=0: visible right after the start edge).
   task automatic pushWindow(input int s, input int n, input logic [31:0] nh,
                             input logic [31:0] nl, input string nm);
      if (n == 0) begin
         q.push_back('{s, 1'b0, nh, nl, nm});
      end else begin
         for (int k = 0; k < n; k++)
            q.push_back('{s + k, (k < n - 1), curHi, curLo, nm});
         q.push_back('{s + n, 1'b0, nh, nl, nm});
      end
      curHi = nh;
      curLo = nl;
   endtask

   task automatic scramble();
      startIn = 1'b0;
      aIn     = $urandom;
      bIn     = $urandom;
      opIn    = 4'($urandom_range(0, 15));
   endtask

   task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] nh, input logic [31:0] nl,
                        input string nm);
      int s;
      @(negedge clk); #2;
      startIn = 1'b1; opIn = op; aIn = a; bIn = b;
      s = cyc + 1;
      pushWindow(s, n, nh, nl, nm);
      @(negedge clk); #2;
      scramble();
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      rstN = 1'b0; startIn = 1'b0; opIn = 4'd0; aIn = '0; bIn = '0;
      q.push_back('{1, 1'b0, 32'd0, 32'd0, "reset1"});
      q.push_back('{2, 1'b0, 32'd0, 32'd0, "reset2"});
      repeat (2) @(negedge clk);
      #2 rstN = 1'b1;

      // Reset in the middle of a divide.
      runOp(c_MTHI, 32'h1234, 32'd0, 0, 32'h1234, curLo, "mthi_pre");
      @(negedge clk); #2;
      startIn = 1'b1; opIn = c_DIV; aIn = 32'd100; bIn = 32'd7;
      s = cyc + 1;
      for (int k = 0; k < 4; k++) q.push_back('{s + k, 1'b1, 32'h1234, 32'd0, "div_abort"});
      @(negedge clk); #2;
      scramble();
      repeat (3) @(negedge clk);
      #2 rstN = 1'b0;
      for (int k = 4; k < 14; k++) q.push_back('{s + k, 1'b0, 32'd0, 32'd0, "rst_mid"});
      repeat (2) @(negedge clk);
      #2 rstN = 1'b1;
      repeat (9) @(negedge clk);
      curHi = 32'd0; curLo = 32'd0;

      // Multiply.
      runOp(c_MULT,  32'hFFFFFFFE, 32'd3, c_MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
      runOp(c_MULTU, 32'hFFFFFFFE, 32'd3, c_MULT_N, 32'h00000002, 32'hFFFFFFFA, "multu");

      // Divide.
      runOp(c_DIV,  32'hFFFFFFF9, 32'd2,        c_DIV_N, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
      runOp(c_DIV,  32'h80000000, 32'hFFFFFFFF, c_DIV_N, 32'h00000000, 32'h80000000, "div_ovf");
      runOp(c_DIV,  32'd7,        32'hFFFFFFFE, c_DIV_N, 32'h00000001, 32'hFFFFFFFD, "div_7_m2");
      runOp(c_DIVU, 32'd100,      32'd7,        c_DIV_N, 32'h00000002, 32'h0000000E, "divu");

      // Moves, divide by zero, no-op starts.
      runOp(c_MTHI, 32'd5, 32'd0, 0, 32'd5, curLo, "mthi");
      runOp(c_MTLO, 32'd1, 32'd0, 0, curHi, 32'd1, "mtlo");
      runOp(c_DIVU, 32'd9, 32'd0, c_DIV_N, 32'd5, 32'd1, "divu_by0");
      runOp(4'd12,  32'hDEAD, 32'hBEEF, 0, curHi, curLo, "reserved");
      runOp(c_NONE, 32'hDEAD, 32'hBEEF, 0, curHi, curLo, "none");

      // Accumulate family.
      runOp(c_MTHI,  32'd0,        32'd0, 0, 32'd0, curLo, "mthi0");
      runOp(c_MTLO,  32'hFFFFFFFF, 32'd0, 0, curHi, 32'hFFFFFFFF, "mtlo_ff");
      runOp(c_MADDU, 32'd1, 32'd1, c_MULT_N, 32'd1, 32'd0, "maddu");
      runOp(c_MSUB,  32'd1, 32'd1, c_MULT_N, 32'd0, 32'hFFFFFFFF, "msub");
      runOp(c_MADD,  32'hFFFFFFFF, 32'd2, c_MULT_N, 32'd0, 32'hFFFFFFFD, "madd");
      runOp(c_MSUBU, 32'd2, 32'd3, c_MULT_N, 32'd0, 32'hFFFFFFF7, "msubu");
      runOp(c_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, c_MULT_N, 32'hFFFFFFFE, 32'hFFFFFFF8, "maddu_big");

      // Starts while busy and on the commit edge are dropped; the next
      // cycle's start is taken.
      @(negedge clk); #2;
      startIn = 1'b1; opIn = c_MULT; aIn = 32'd3; bIn = 32'd4;
      s = cyc + 1;
      pushWindow(s, c_MULT_N, 32'd0, 32'd12, "mult_first");
      @(negedge clk); #2;
      startIn = 1'b1; opIn = c_MULTU; aIn = 32'd100; bIn = 32'd100;
      @(negedge clk); #2;
      scramble();
      repeat (3) @(negedge clk);
      #2;
      startIn = 1'b1; opIn = c_MULTU; aIn = 32'd7; bIn = 32'd7;
      @(negedge clk); #2;
      startIn = 1'b1; opIn = c_MULT; aIn = 32'hFFFFFFFE; bIn = 32'd5;
      pushWindow(cyc + 1, c_MULT_N, 32'hFFFFFFFF, 32'hFFFFFFF6, "mult_b2b");
      @(negedge clk); #2;
      scramble();
      repeat (c_MULT_N + 2) @(negedge clk);

      for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: pending=%0d expected=0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
